// File: rtl/inertial_fusion_cal_pkg.sv
// Shared types and default constants for the inertial rate/accel fusion block.
// Holds the controller state encoding and the fixed accel-to-angle shift.
package inertial_fusion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } fusion_state_e;

    localparam int DEF_NUM_AXES    = 2;
    localparam int DEF_CAL_LOG2    = 8;
    localparam int DEF_FUSION_STEP = 512;
    localparam int DEF_ACC_SCALE   = 327;
    localparam int DEF_INT_W       = 27;

    // Accel product is scaled down by 2^ACC_SHIFT to land in angle units.
    localparam int ACC_SHIFT = 13;

endpackage

// File: rtl/inertial_fusion_cal_axis.sv
// One fusion channel: offset averaging during calibration, then a
// complementary-style integrator nudged toward the accel-derived angle.
module fusion_axis
    import inertial_fusion_pkg::*;
#(
    parameter int CAL_LOG2    = DEF_CAL_LOG2,
    parameter int FUSION_STEP = DEF_FUSION_STEP,
    parameter int ACC_SCALE   = DEF_ACC_SCALE,
    parameter int INT_W       = DEF_INT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        cal_acc_i,
    input  logic        cal_last_i,
    input  logic        run_upd_i,
    input  logic [15:0] rate_i,
    input  logic [15:0] acc_i,
    output logic [15:0] angle_o
);

    localparam int SUM_W = 16 + CAL_LOG2;
    localparam int EXT_W = INT_W + 2;
    localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'({1'b0, {(INT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN  = -SAT_MAX - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] STEP_POS = EXT_W'(FUSION_STEP);

    logic signed [SUM_W-1:0] rate_sum_q, rate_sum_d, acc_sum_q, acc_sum_d;
    logic signed [SUM_W-1:0] rate_sum_nxt, acc_sum_nxt;
    logic signed [15:0]      rate_off_q, rate_off_d, acc_off_q, acc_off_d;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [16:0]      rate_c, acc_c;
    logic signed [31:0]      acc_prod;
    logic signed [15:0]      acc_ang, angle_s;
    logic signed [EXT_W-1:0] step_ext, integ_sum, integ_sat;

    // Sums include the current sample so the terminal sample is part of the average.
    assign rate_sum_nxt = rate_sum_q + {{CAL_LOG2{rate_i[15]}}, rate_i};
    assign acc_sum_nxt  = acc_sum_q  + {{CAL_LOG2{acc_i[15]}},  acc_i};

    assign rate_c   = {rate_i[15], rate_i} - {rate_off_q[15], rate_off_q};
    assign acc_c    = {acc_i[15], acc_i}   - {acc_off_q[15], acc_off_q};
    assign acc_prod = 32'(acc_c) * 32'(ACC_SCALE);
    assign acc_ang  = 16'(acc_prod >>> ACC_SHIFT);
    assign angle_s  = integ_q[INT_W-1 -: 16];
    assign angle_o  = angle_s;

    // Integrator sum is two bits wider than the register so overflow is visible before clamping.
    assign step_ext  = (acc_ang > angle_s) ? STEP_POS : -STEP_POS;
    assign integ_sum = EXT_W'(integ_q) - EXT_W'(rate_c) + step_ext;

    always_comb begin
        if (integ_sum > SAT_MAX) begin
            integ_sat = SAT_MAX;
        end else if (integ_sum < SAT_MIN) begin
            integ_sat = SAT_MIN;
        end else begin
            integ_sat = integ_sum;
        end
    end

    always_comb begin
        rate_sum_d = rate_sum_q;
        acc_sum_d  = acc_sum_q;
        rate_off_d = rate_off_q;
        acc_off_d  = acc_off_q;
        integ_d    = integ_q;
        if (clear_i) begin
            rate_sum_d = '0;
            acc_sum_d  = '0;
            rate_off_d = '0;
            acc_off_d  = '0;
            integ_d    = '0;
        end else if (cal_acc_i) begin
            rate_sum_d = rate_sum_nxt;
            acc_sum_d  = acc_sum_nxt;
            if (cal_last_i) begin
                rate_off_d = rate_sum_nxt[CAL_LOG2 +: 16];
                acc_off_d  = acc_sum_nxt[CAL_LOG2 +: 16];
            end
        end else if (run_upd_i) begin
            integ_d = integ_sat[INT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_sum_q <= '0;
            acc_sum_q  <= '0;
            rate_off_q <= '0;
            acc_off_q  <= '0;
            integ_q    <= '0;
        end else begin
            rate_sum_q <= rate_sum_d;
            acc_sum_q  <= acc_sum_d;
            rate_off_q <= rate_off_d;
            acc_off_q  <= acc_off_d;
            integ_q    <= integ_d;
        end
    end

endmodule

// File: rtl/inertial_fusion_cal.sv
// Multi-axis inertial fusion with start-up offset calibration.
// The controller FSM and sample counter live here; per-axis math is in fusion_axis.
module inertial_fusion_cal
    import inertial_fusion_pkg::*;
#(
    parameter int NUM_AXES    = DEF_NUM_AXES,
    parameter int CAL_LOG2    = DEF_CAL_LOG2,
    parameter int FUSION_STEP = DEF_FUSION_STEP,
    parameter int ACC_SCALE   = DEF_ACC_SCALE,
    parameter int INT_W       = DEF_INT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic                    cal_start,
    input  logic [16*NUM_AXES-1:0]  rate,
    input  logic [16*NUM_AXES-1:0]  acc,
    output logic [16*NUM_AXES-1:0]  angle,
    output logic                    angle_vld,
    output logic                    cal_done,
    output logic                    calibrated
);

    fusion_state_e       state_q, state_d;
    logic [CAL_LOG2-1:0] count_q, count_d;
    logic                angle_vld_q, angle_vld_d;
    logic                cal_done_q, cal_done_d;
    logic                cal_acc, cal_last, run_upd;

    // Counter holds samples taken so far; all-ones means this vld is the last one.
    assign cal_last = &count_q;

    // cal_start overrides everything, including a coincident sample.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        angle_vld_d = 1'b0;
        cal_done_d  = 1'b0;
        cal_acc     = 1'b0;
        run_upd     = 1'b0;
        if (cal_start) begin
            state_d = ST_CAL;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_CAL: begin
                    if (vld) begin
                        cal_acc = 1'b1;
                        count_d = count_q + CAL_LOG2'(1);
                        if (cal_last) begin
                            state_d    = ST_RUN;
                            cal_done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (vld) begin
                        run_upd     = 1'b1;
                        angle_vld_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            angle_vld_q <= 1'b0;
            cal_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            angle_vld_q <= angle_vld_d;
            cal_done_q  <= cal_done_d;
        end
    end

    assign angle_vld  = angle_vld_q;
    assign cal_done   = cal_done_q;
    assign calibrated = (state_q == ST_RUN);

    for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
        fusion_axis #(
            .CAL_LOG2    (CAL_LOG2),
            .FUSION_STEP (FUSION_STEP),
            .ACC_SCALE   (ACC_SCALE),
            .INT_W       (INT_W)
        ) u_axis (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (cal_start),
            .cal_acc_i  (cal_acc),
            .cal_last_i (cal_last),
            .run_upd_i  (run_upd),
            .rate_i     (rate[16*k +: 16]),
            .acc_i      (acc[16*k +: 16]),
            .angle_o    (angle[16*k +: 16])
        );
    end

endmodule

// File: tb/tb_inertial_fusion_cal.sv
// Self-checking bench for inertial_fusion_cal: vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_inertial_fusion_cal;

    localparam int NA       = 2;
    localparam int CAL_LOG2 = 8;
    localparam int CAL_N    = 1 << CAL_LOG2;
    localparam int STEP     = 512;
    localparam int SCALE    = 327;
    localparam int INT_W    = 27;
    localparam longint ANG_DIV = longint'(1) << (INT_W - 16);
    localparam longint INT_MAX = (longint'(1) << (INT_W - 1)) - 1;
    localparam longint INT_MIN = -(longint'(1) << (INT_W - 1));

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vld;
    logic            cal_start;
    logic [16*NA-1:0] rate;
    logic [16*NA-1:0] acc;
    logic [16*NA-1:0] angle;
    logic            angle_vld;
    logic            cal_done;
    logic            calibrated;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inertial_fusion_cal #(
        .NUM_AXES    (NA),
        .CAL_LOG2    (CAL_LOG2),
        .FUSION_STEP (STEP),
        .ACC_SCALE   (SCALE),
        .INT_W       (INT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld        (vld),
        .cal_start  (cal_start),
        .rate       (rate),
        .acc        (acc),
        .angle      (angle),
        .angle_vld  (angle_vld),
        .cal_done   (cal_done),
        .calibrated (calibrated)
    );

    // Reference model: mode 0 = idle, 1 = calibrating, 2 = running.
    int     mMode;
    int     mCount;
    longint mRateSum[NA];
    longint mAccSum[NA];
    longint mRateOff[NA];
    longint mAccOff[NA];
    longint mInteg[NA];
    bit     mAngleVld;
    bit     mCalDone;

    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint s16(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint wrapS16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return longint'($signed(t));
    endfunction

    function automatic logic [31:0] modelAngle();
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < NA; k++) res[16*k +: 16] = 16'(floorDiv(mInteg[k], ANG_DIV));
        return res;
    endfunction

    task automatic modelReset();
        mMode = 0; mCount = 0; mAngleVld = 0; mCalDone = 0;
        for (int k = 0; k < NA; k++) begin
            mRateSum[k] = 0; mAccSum[k] = 0; mRateOff[k] = 0; mAccOff[k] = 0; mInteg[k] = 0;
        end
    endtask

    task automatic modelStep(input logic v, input logic c, input logic [31:0] r, input logic [31:0] a);
        longint rc, ac, ang, cur, nxt;
        mAngleVld = 0;
        mCalDone  = 0;
        if (c) begin
            mMode = 1; mCount = 0;
            for (int k = 0; k < NA; k++) begin
                mRateSum[k] = 0; mAccSum[k] = 0; mRateOff[k] = 0; mAccOff[k] = 0; mInteg[k] = 0;
            end
        end else if (mMode == 1 && v) begin
            mCount++;
            for (int k = 0; k < NA; k++) begin
                mRateSum[k] += s16(r[16*k +: 16]);
                mAccSum[k]  += s16(a[16*k +: 16]);
            end
            if (mCount == CAL_N) begin
                for (int k = 0; k < NA; k++) begin
                    mRateOff[k] = floorDiv(mRateSum[k], CAL_N);
                    mAccOff[k]  = floorDiv(mAccSum[k], CAL_N);
                end
                mMode = 2;
                mCalDone = 1;
            end
        end else if (mMode == 2 && v) begin
            for (int k = 0; k < NA; k++) begin
                rc  = s16(r[16*k +: 16]) - mRateOff[k];
                ac  = s16(a[16*k +: 16]) - mAccOff[k];
                ang = wrapS16(floorDiv(ac * SCALE, 8192));
                cur = floorDiv(mInteg[k], ANG_DIV);
                nxt = mInteg[k] - rc + ((ang > cur) ? STEP : -STEP);
                if (nxt > INT_MAX) nxt = INT_MAX;
                if (nxt < INT_MIN) nxt = INT_MIN;
                mInteg[k] = nxt;
            end
            mAngleVld = 1;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkCond(input string name, input bit ok, input logic [31:0] act);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s: got %h (out of allowed range)", name, act);
        end
    endtask

    // Drive one cycle's inputs, clock it, advance the model and settle past the edge.
    task automatic applyStimulus(input logic v, input logic c, input logic [31:0] r, input logic [31:0] a);
        vld = v; cal_start = c; rate = r; acc = a;
        @(posedge clk);
        modelStep(v, c, r, a);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".angle"},      angle,            modelAngle());
        checkVal({tag, ".angle_vld"},  32'(angle_vld),   32'(mAngleVld));
        checkVal({tag, ".cal_done"},   32'(cal_done),    32'(mCalDone));
        checkVal({tag, ".calibrated"}, 32'(calibrated),  32'(mMode == 2));
    endtask

    task automatic cycle(input logic v, input logic c, input logic [31:0] r, input logic [31:0] a, input string tag);
        applyStimulus(v, c, r, a);
        checkOutput(tag);
    endtask

    typedef struct {
        logic        v;
        logic        c;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] expAngle;
        logic        expVld;
        logic        expCal;
        logic        expDone;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int doneCount;
        int vldCount;
        int negCount;
        logic [15:0] prevAng[NA];
        logic [15:0] ax;
        logic v, c;

        vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0F0F_F0F0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h7FFF_8000, 32'h8000_7FFF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0100_0200, 32'h0300_0400, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0100_0200, 32'h0300_0400, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; vld = 1'b0; cal_start = 1'b0; rate = '0; acc = '0;
        modelReset();
        #3;
        checkVal("reset.angle",      angle,           32'h0);
        checkVal("reset.angle_vld",  32'(angle_vld),  32'h0);
        checkVal("reset.cal_done",   32'(cal_done),   32'h0);
        checkVal("reset.calibrated", 32'(calibrated), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle ignores samples; cal_start beats a coincident vld; cal samples give no angle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].v, vecs[i].c, vecs[i].r, vecs[i].a);
            checkVal($sformatf("vec%0d.angle", i),      angle,           vecs[i].expAngle);
            checkVal($sformatf("vec%0d.angle_vld", i),  32'(angle_vld),  32'(vecs[i].expVld));
            checkVal($sformatf("vec%0d.calibrated", i), 32'(calibrated), 32'(vecs[i].expCal));
            checkVal($sformatf("vec%0d.cal_done", i),   32'(cal_done),   32'(vecs[i].expDone));
        end

        // Constant-input calibration, one cal_done right after the last sample.
        doneCount = 0;
        for (int i = 0; i < CAL_N; i++) begin
            cycle(1'b1, 1'b0, 32'h03C2_03C2, 32'hFE80_FE80, "cal");
            doneCount += int'(cal_done);
            if (i == CAL_N - 1) begin
                checkVal("cal.done_at_last", 32'(cal_done),   32'h1);
                checkVal("cal.calibrated",   32'(calibrated), 32'h1);
            end
            cycle(1'b0, 1'b0, 32'h03C2_03C2, 32'hFE80_FE80, "cal_gap");
            doneCount += int'(cal_done);
        end
        checkVal("cal.done_count", 32'(doneCount), 32'd1);

        // Inputs equal to offsets: angle dithers between 0 and -1.
        vldCount = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 32'h03C2_03C2, 32'hFE80_FE80, "osc");
            vldCount += int'(angle_vld);
            for (int k = 0; k < NA; k++) begin
                ax = angle[16*k +: 16];
                checkCond($sformatf("osc.axis%0d", k), (ax == 16'h0000) || (ax == 16'hFFFF), 32'(ax));
            end
            cycle(1'b0, 1'b0, 32'h03C2_03C2, 32'hFE80_FE80, "osc_gap");
            vldCount += int'(angle_vld);
        end
        checkVal("osc.vld_count", 32'(vldCount), 32'd100);

        // Rate bias of -1000 below offset drives the angle steadily upward.
        for (int k = 0; k < NA; k++) prevAng[k] = angle[16*k +: 16];
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0, 32'hFFDA_FFDA, 32'hFE80_FE80, "ramp");
            for (int k = 0; k < NA; k++) begin
                ax = angle[16*k +: 16];
                checkCond($sformatf("ramp.mono%0d", k), $signed(ax) >= $signed(prevAng[k]), 32'(ax));
                prevAng[k] = ax;
            end
        end
        checkCond("ramp.positive", $signed(angle[15:0]) > 0, 32'(angle[15:0]));

        // cal_start with vld while running: sample dropped, back to calibrating.
        cycle(1'b1, 1'b1, 32'hFFDA_FFDA, 32'hFE80_FE80, "restart");
        checkVal("restart.angle_vld",  32'(angle_vld),  32'h0);
        checkVal("restart.calibrated", 32'(calibrated), 32'h0);
        checkVal("restart.angle",      angle,           32'h0);

        // Calibrate at +max rate, then feed most-negative rate until the integrator pins.
        for (int i = 0; i < CAL_N; i++) cycle(1'b1, 1'b0, 32'h7FFF_7FFF, 32'h0, "satcal");
        negCount = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b1, 1'b0, 32'h8000_8000, 32'h0, "sat");
            for (int k = 0; k < NA; k++) if (angle[16*k + 15]) negCount++;
            cycle(1'b0, 1'b0, 32'h8000_8000, 32'h0, "sat_gap");
        end
        checkVal("sat.neg_count", 32'(negCount), 32'h0);
        checkVal("sat.angle",     angle,         32'h7FFF_7FFF);

        // Async reset in the middle of calibration wipes everything.
        cycle(1'b0, 1'b1, 32'h0, 32'h0, "midcal_start");
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 32'h0123_0456, 32'h0789_0ABC, "midcal");
        vld = 1'b0; cal_start = 1'b0;
        rst_n = 1'b0;
        #2;
        modelReset();
        checkVal("midrst.angle",      angle,           32'h0);
        checkVal("midrst.calibrated", 32'(calibrated), 32'h0);
        checkVal("midrst.angle_vld",  32'(angle_vld),  32'h0);
        checkVal("midrst.cal_done",   32'(cal_done),   32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 32'h0123_0456, 32'h0789_0ABC, "postrst");
        checkVal("postrst.calibrated", 32'(calibrated), 32'h0);

        // Randomized traffic, including occasional restarts.
        cycle(1'b0, 1'b1, 32'h0, 32'h0, "rnd_start");
        for (int i = 0; i < 4000; i++) begin
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 1499) == 0);
            cycle(v, c, $urandom, $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
